// File: rtl/dmem_arb_pkg.sv
// Shared types and helpers for the two-port data-memory arbiter.
package dmem_arb_pkg;

  localparam int NUM_PORTS = 2;
  // Widest word the byte-merge helper handles; callers size-cast in and out.
  localparam int MAX_DW    = 256;
  localparam int MAX_BE    = MAX_DW / 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    MERGE  = 2'd2,
    RESP   = 2'd3
  } dmem_arb_state_t;

  typedef logic [$clog2(NUM_PORTS)-1:0] port_idx_t;

  // Take each byte from new_w where its enable is set, else keep old_w.
  function automatic logic [MAX_DW-1:0] merge_bytes(input logic [MAX_DW-1:0] old_w,
                                                    input logic [MAX_DW-1:0] new_w,
                                                    input logic [MAX_BE-1:0] be);
    logic [MAX_DW-1:0] m;
    m = old_w;
    for (int i = 0; i < MAX_BE; i++)
      if (be[i]) m[i*8 +: 8] = new_w[i*8 +: 8];
    return m;
  endfunction

endpackage

// File: rtl/dmem_arb_if.sv
// Request/response bundle between the two requesters and the arbiter.
// Port index p selects the slice of each per-port packed field.
interface dmem_arb_if #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH    = 32
);
  localparam int BE_W = DATA_WIDTH / 8;

  logic [1:0]                    req_valid;
  logic [1:0]                    req_ready;
  logic [1:0]                    req_we;
  logic [1:0][ADDRESS_WIDTH-1:0] req_addr;
  logic [1:0][DATA_WIDTH-1:0]    req_wdata;
  logic [1:0][BE_W-1:0]          req_be;
  logic [1:0]                    resp_valid;
  logic [DATA_WIDTH-1:0]         resp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be,
    input  req_ready, resp_valid, resp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be,
    output req_ready, resp_valid, resp_rdata
  );
endinterface

// File: rtl/dmem_rr_arbiter.sv
// Two-way grant selection from per-port valids.
// DMEM_ARB_FIXED_PRIO_EN: port 0 always wins a tie and no rr_last input exists;
// otherwise a tie goes to the port that did not win last.
module dmem_rr_arbiter
  import dmem_arb_pkg::*;
(
  input  logic [NUM_PORTS-1:0] valid_i,
`ifndef DMEM_ARB_FIXED_PRIO_EN
  input  port_idx_t            rr_last_i,
`endif
  output logic [NUM_PORTS-1:0] gnt_o,
  output port_idx_t            gnt_idx_o,
  output logic                 gnt_any_o
);

  // Pick the winner; a lone valid port wins regardless of history.
  always_comb begin
    gnt_any_o = |valid_i;
    if (&valid_i) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
      gnt_idx_o = 1'b0;
`else
      gnt_idx_o = ~rr_last_i;
`endif
    end else begin
      gnt_idx_o = valid_i[1];
    end
    gnt_o = gnt_any_o ? (gnt_idx_o ? 2'b10 : 2'b01) : 2'b00;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-port data memory (sync write,
// async read). Each accepted request walks IDLE -> ACCESS -> (MERGE) ->
// RESP; partial-byte stores do a read-modify-write through MERGE.
// Optional macro DMEM_ARB_FIXED_PRIO_EN selects fixed port-0 priority.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  dmem_arb_if.slave                bus,
  output logic                     mem_we,
  output logic [ADDRESS_WIDTH-1:0] mem_a,
  output logic [DATA_WIDTH-1:0]    mem_wd,
  input  logic [DATA_WIDTH-1:0]    mem_rd
);

  localparam int BE_W = DATA_WIDTH / 8;
  localparam logic [BE_W-1:0] BE_FULL = {BE_W{1'b1}};

  localparam logic [1:0] S_IDLE   = IDLE;
  localparam logic [1:0] S_ACCESS = ACCESS;
  localparam logic [1:0] S_MERGE  = MERGE;
  localparam logic [1:0] S_RESP   = RESP;

  logic [1:0]               state_q, state_d;
  logic                     we_q, we_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
  logic [BE_W-1:0]          be_q, be_d;
  port_idx_t                port_q, port_d;
  // Holds the loaded word for loads and the old word for partial stores.
  logic [DATA_WIDTH-1:0]    data_q, data_d;

  logic [1:0]               gnt;
  port_idx_t                gnt_idx;
  logic                     gnt_any;

`ifndef DMEM_ARB_FIXED_PRIO_EN
  port_idx_t                rr_last_q, rr_last_d;
`endif

  dmem_rr_arbiter u_arb (
    .valid_i   (bus.req_valid),
`ifndef DMEM_ARB_FIXED_PRIO_EN
    .rr_last_i (rr_last_q),
`endif
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx),
    .gnt_any_o (gnt_any)
  );

  // Ready only in IDLE, and forced low while reset is held.
  always_comb begin
    bus.req_ready = 2'b00;
    if (rst_n && state_q == S_IDLE) bus.req_ready = gnt;
  end

  // Next-state and request-latching logic.
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    port_d  = port_q;
    data_d  = data_q;
    case (state_q)
      S_IDLE: begin
        if (gnt_any) begin
          we_d    = bus.req_we[gnt_idx];
          addr_d  = bus.req_addr[gnt_idx];
          wdata_d = bus.req_wdata[gnt_idx];
          be_d    = bus.req_be[gnt_idx];
          port_d  = gnt_idx;
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (!we_q) begin
          data_d  = mem_rd;
          state_d = S_RESP;
        end else if (be_q == BE_FULL || be_q == '0) begin
          state_d = S_RESP;
        end else begin
          data_d  = mem_rd;
          state_d = S_MERGE;
        end
      end
      S_MERGE: state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

`ifndef DMEM_ARB_FIXED_PRIO_EN
  // Remember the last winner so the next tie goes the other way.
  always_comb begin
    rr_last_d = rr_last_q;
    if (state_q == S_IDLE && gnt_any) rr_last_d = gnt_idx;
  end

  // Round-robin history; starts at 1 so port 0 takes the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_last_q <= 1'b1;
    else        rr_last_q <= rr_last_d;
  end
`endif

  // Transaction registers; a reset mid-access simply drops the request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      port_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      port_q  <= port_d;
      data_q  <= data_d;
    end
  end

  // Memory-side drive: write only in ACCESS (full word) or MERGE.
  always_comb begin
    mem_we = 1'b0;
    mem_a  = '0;
    mem_wd = '0;
    case (state_q)
      S_ACCESS: begin
        mem_a = addr_q;
        if (we_q && be_q == BE_FULL) begin
          mem_we = 1'b1;
          mem_wd = wdata_q;
        end
      end
      S_MERGE: begin
        mem_we = 1'b1;
        mem_a  = addr_q;
        mem_wd = DATA_WIDTH'(merge_bytes(MAX_DW'(data_q), MAX_DW'(wdata_q), MAX_BE'(be_q)));
      end
      default: ;
    endcase
  end

  // One-cycle response to the port that was granted; stores return zero.
  always_comb begin
    bus.resp_valid = 2'b00;
    bus.resp_rdata = '0;
    if (state_q == S_RESP) begin
      bus.resp_valid = port_q ? 2'b10 : 2'b01;
      if (!we_q) bus.resp_rdata = data_q;
    end
  end

endmodule
